// File: rtl/hazard_forward_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_pkg
// Shared types, constants and helpers for the parametrised hazard/forwarding
// unit of the 5-stage RV32I core.
//   - OPCODE_* : RV32I major opcodes
//   - write_back_mux_selector : per-stage writeback source (NO_WRITEBACK = none)
//   - forward_sel_t  : forwarding select, wide enough for up to 4 stages
//   - hazard_state_e : hold-controller states
//   - ex_info_t      : bundle describing the instruction in ID/EX
//   - uses_rs1/uses_rs2 : source-register usage per opcode
// -----------------------------------------------------------------------------
package hazard_forward_unit_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam int WB_SEL_W = 2;

    typedef enum logic [WB_SEL_W-1:0] {
        NO_WRITEBACK = 2'd0,
        WB_ALU       = 2'd1,
        WB_MEM       = 2'd2,
        WB_PC4       = 2'd3
    } write_back_mux_selector;

    // Four stages at most, so selects 0..4 fit in three bits.
    localparam int FWD_SEL_MAX_W = 3;
    typedef logic [FWD_SEL_MAX_W-1:0] forward_sel_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } hazard_state_e;

    // Widest register index the bundle carries; narrower indices are
    // zero-extended into it.
    localparam int REG_IDX_MAX_W = 8;

    typedef struct packed {
        logic                     valid;
        logic                     is_load;
        logic                     mc_start;
        logic [REG_IDX_MAX_W-1:0] dest;
    } ex_info_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH,
            OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: used = 1'b1;
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL:   used = 1'b0;
            default:                                used = 1'b0;
        endcase
        return used;
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: used = 1'b1;
            default:                                used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_match_enc.sv
// -----------------------------------------------------------------------------
// fwd_match_enc
// Compares one source register against every downstream result stage and
// priority-encodes the youngest match (stage 0 wins) into a forward select.
//   i_src_used     : the instruction actually reads this source
//   i_src          : source register index
//   i_stage_valid  : per-stage valid
//   i_stage_wb_mux : per-stage writeback select
//   i_stage_dest   : per-stage destination register
//   o_sel          : 0 = register file, k+1 = result of stage k
// -----------------------------------------------------------------------------
module fwd_match_enc
    import hazard_forward_unit_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_ADDR_W     = 5,
    parameter int FWD_SEL_W      = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                                   i_src_used,
    input  logic [REG_ADDR_W-1:0]                  i_src,
    input  logic [NUM_FWD_STAGES-1:0]              i_stage_valid,
    input  logic [NUM_FWD_STAGES-1:0][WB_SEL_W-1:0] i_stage_wb_mux,
    input  logic [NUM_FWD_STAGES-1:0][REG_ADDR_W-1:0] i_stage_dest,
    output logic [FWD_SEL_W-1:0]                   o_sel
);

    logic [NUM_FWD_STAGES-1:0] w_hit;
    forward_sel_t              w_sel_full;

    // Per-stage candidate: writes a real register equal to the source.
    always_comb begin
        w_hit = {NUM_FWD_STAGES{1'b0}};
        for (int k = 0; k < NUM_FWD_STAGES; k++) begin
            w_hit[k] = i_stage_valid[k]
                     & (i_stage_wb_mux[k] != NO_WRITEBACK)
                     & (i_stage_dest[k] != {REG_ADDR_W{1'b0}})
                     & (i_stage_dest[k] == i_src);
        end
    end

    // Scan oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
        w_sel_full = {FWD_SEL_MAX_W{1'b0}};
        if (i_src_used) begin
            for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                if (w_hit[k]) begin
                    w_sel_full = forward_sel_t'(k + 1);
                end else begin
                    w_sel_full = w_sel_full;
                end
            end
        end else begin
            w_sel_full = {FWD_SEL_MAX_W{1'b0}};
        end
    end

    assign o_sel = FWD_SEL_W'(w_sel_full);

endmodule

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
// Forwarding, load-use detection, multi-cycle EX hold and stall statistics for
// the 5-stage RV32I core.
//   clk, reset            : core clock, synchronous active-high reset
//   idex_*_ip             : opcode/sources of the ID/EX instruction
//   stage_*_ip            : valid/writeback/dest of the downstream stages
//                           (index 0 = EX/MEM, youngest)
//   ifid_*_ip             : opcode/sources of the IF/ID instruction
//   ex_valid/is_load/mc_start_ip : attributes of the ID/EX instruction
//   flush_ip              : taken branch/jump flush
//   stall_cnt_clr_ip      : clear the statistics counter
//   fa_sel_op, fb_sel_op  : rs1/rs2 forward selects (combinational)
//   stall_op, bubble_op, ex_hold_op : pipeline control (combinational)
//   stall_cycles_op       : saturating count of stalled cycles
// NUM_FWD_STAGES must lie in 1..4.
// -----------------------------------------------------------------------------
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_ADDR_W     = 5,
    parameter int MC_LATENCY     = 4,
    parameter int STALL_CNT_W    = 16,
    localparam int FWD_SEL_W     = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [6:0]                               idex_opcode_ip,
    input  logic [REG_ADDR_W-1:0]                    idex_rs1_ip,
    input  logic [REG_ADDR_W-1:0]                    idex_rs2_ip,
    input  logic [NUM_FWD_STAGES-1:0]                stage_valid_ip,
    input  logic [NUM_FWD_STAGES-1:0][WB_SEL_W-1:0]  stage_wb_mux_ip,
    input  logic [NUM_FWD_STAGES-1:0][REG_ADDR_W-1:0] stage_dest_ip,
    input  logic [6:0]                               ifid_opcode_ip,
    input  logic [REG_ADDR_W-1:0]                    ifid_rs1_ip,
    input  logic [REG_ADDR_W-1:0]                    ifid_rs2_ip,
    input  logic                                     ex_valid_ip,
    input  logic                                     ex_is_load_ip,
    input  logic                                     ex_mc_start_ip,
    input  logic                                     flush_ip,
    input  logic                                     stall_cnt_clr_ip,
    output logic [FWD_SEL_W-1:0]                     fa_sel_op,
    output logic [FWD_SEL_W-1:0]                     fb_sel_op,
    output logic                                     stall_op,
    output logic                                     bubble_op,
    output logic                                     ex_hold_op,
    output logic [STALL_CNT_W-1:0]                   stall_cycles_op
);

    // Busy counter only needs to hold MC_LATENCY-2.
    localparam int BUSY_CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
    localparam logic [BUSY_CNT_W-1:0] BUSY_LOAD =
        BUSY_CNT_W'((MC_LATENCY > 2) ? (MC_LATENCY - 2) : 0);
    localparam logic [BUSY_CNT_W-1:0] BUSY_ONE  = BUSY_CNT_W'(1);
    localparam logic MC_HOLDS      = (MC_LATENCY > 1);
    localparam logic MC_NEEDS_BUSY = (MC_LATENCY > 2);
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_ONE = STALL_CNT_W'(1);

    hazard_state_e             r_state;
    hazard_state_e             w_state_nxt;
    logic [BUSY_CNT_W-1:0]     r_busy_cnt;
    logic [BUSY_CNT_W-1:0]     w_busy_cnt_nxt;
    logic [STALL_CNT_W-1:0]    r_stall_cnt;

    ex_info_t                  w_ex;
    logic                      w_idex_rs1_used;
    logic                      w_idex_rs2_used;
    logic                      w_ifid_rs1_used;
    logic                      w_ifid_rs2_used;
    logic                      w_luse;
    logic                      w_stall;
    logic                      w_bubble;
    logic                      w_hold;

    // -------------------------------------------------------------------------
    // Forwarding
    // -------------------------------------------------------------------------
    assign w_idex_rs1_used = uses_rs1(idex_opcode_ip);
    assign w_idex_rs2_used = uses_rs2(idex_opcode_ip);

    fwd_match_enc #(
        .NUM_FWD_STAGES (NUM_FWD_STAGES),
        .REG_ADDR_W     (REG_ADDR_W),
        .FWD_SEL_W      (FWD_SEL_W)
    ) u_fwd_rs1 (
        .i_src_used     (w_idex_rs1_used),
        .i_src          (idex_rs1_ip),
        .i_stage_valid  (stage_valid_ip),
        .i_stage_wb_mux (stage_wb_mux_ip),
        .i_stage_dest   (stage_dest_ip),
        .o_sel          (fa_sel_op)
    );

    fwd_match_enc #(
        .NUM_FWD_STAGES (NUM_FWD_STAGES),
        .REG_ADDR_W     (REG_ADDR_W),
        .FWD_SEL_W      (FWD_SEL_W)
    ) u_fwd_rs2 (
        .i_src_used     (w_idex_rs2_used),
        .i_src          (idex_rs2_ip),
        .i_stage_valid  (stage_valid_ip),
        .i_stage_wb_mux (stage_wb_mux_ip),
        .i_stage_dest   (stage_dest_ip),
        .o_sel          (fb_sel_op)
    );

    // -------------------------------------------------------------------------
    // Load-use detection
    // The core presents the ID/EX destination on stage_dest_ip[0] alongside
    // the load flag, so that lane doubles as the ex_dest for this check.
    // -------------------------------------------------------------------------
    assign w_ex.valid    = ex_valid_ip;
    assign w_ex.is_load  = ex_is_load_ip;
    assign w_ex.mc_start = ex_mc_start_ip;
    assign w_ex.dest     = REG_IDX_MAX_W'(stage_dest_ip[0]);

    assign w_ifid_rs1_used = uses_rs1(ifid_opcode_ip);
    assign w_ifid_rs2_used = uses_rs2(ifid_opcode_ip);

    assign w_luse = w_ex.valid & w_ex.is_load
                  & (w_ex.dest != {REG_IDX_MAX_W{1'b0}})
                  & ((w_ifid_rs1_used & (REG_IDX_MAX_W'(ifid_rs1_ip) == w_ex.dest))
                   | (w_ifid_rs2_used & (REG_IDX_MAX_W'(ifid_rs2_ip) == w_ex.dest)));

    // -------------------------------------------------------------------------
    // Hold controller
    // The entry cycle in RUN already holds, so MC_BUSY runs for MC_LATENCY-2
    // cycles: the counter is loaded with MC_LATENCY-2 and the cycle whose
    // decrement would reach zero is the last one held.
    // -------------------------------------------------------------------------

    // Next-state and control decode for the hold controller.
    always_comb begin
        w_state_nxt    = r_state;
        w_busy_cnt_nxt = r_busy_cnt;
        w_stall        = 1'b0;
        w_bubble       = 1'b0;
        w_hold         = 1'b0;
        case (r_state)
            RUN: begin
                if (flush_ip) begin
                    w_stall = 1'b0;
                end else if (w_luse) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_ex.valid && w_ex.mc_start && MC_HOLDS) begin
                    w_stall = 1'b1;
                    w_hold  = 1'b1;
                    if (MC_NEEDS_BUSY) begin
                        w_state_nxt    = MC_BUSY;
                        w_busy_cnt_nxt = BUSY_LOAD;
                    end else begin
                        w_state_nxt    = RUN;
                    end
                end else begin
                    w_state_nxt = RUN;
                end
            end
            MC_BUSY: begin
                // Load-use and flush cannot disturb an op already in EX.
                w_stall = 1'b1;
                w_hold  = 1'b1;
                if (r_busy_cnt <= BUSY_ONE) begin
                    w_state_nxt    = RUN;
                    w_busy_cnt_nxt = {BUSY_CNT_W{1'b0}};
                end else begin
                    w_busy_cnt_nxt = r_busy_cnt - BUSY_ONE;
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_busy_cnt_nxt = {BUSY_CNT_W{1'b0}};
            end
        endcase
    end

    // Hold-controller state and busy counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_busy_cnt <= {BUSY_CNT_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end

    // Saturating stall statistics; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (stall_cnt_clr_ip) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != STALL_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_op        = w_stall;
    assign bubble_op       = w_bubble;
    assign ex_hold_op      = w_hold;
    assign stall_cycles_op = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

    localparam int N   = 2;
    localparam int RW  = 5;
    localparam int MCL = 4;
    localparam int CW  = 2;
    localparam int SW  = $clog2(N + 1);

    logic                    clk = 1'b0;
    logic                    reset;
    logic [6:0]              idex_opcode;
    logic [RW-1:0]           idex_rs1, idex_rs2;
    logic [N-1:0]            stage_valid;
    logic [N-1:0][1:0]       stage_wb_mux;
    logic [N-1:0][RW-1:0]    stage_dest;
    logic [6:0]              ifid_opcode;
    logic [RW-1:0]           ifid_rs1, ifid_rs2;
    logic                    ex_valid, ex_is_load, ex_mc_start, flush, clr;
    logic [SW-1:0]           fa_sel, fb_sel;
    logic                    stall, bubble, hold;
    logic [CW-1:0]           stall_cycles;

    typedef struct {
        string         name;
        logic          cnt_only;
        logic [SW-1:0] fa;
        logic [SW-1:0] fb;
        logic          stall;
        logic          bubble;
        logic          hold;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .NUM_FWD_STAGES (N),
        .REG_ADDR_W     (RW),
        .MC_LATENCY     (MCL),
        .STALL_CNT_W    (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .idex_opcode_ip   (idex_opcode),
        .idex_rs1_ip      (idex_rs1),
        .idex_rs2_ip      (idex_rs2),
        .stage_valid_ip   (stage_valid),
        .stage_wb_mux_ip  (stage_wb_mux),
        .stage_dest_ip    (stage_dest),
        .ifid_opcode_ip   (ifid_opcode),
        .ifid_rs1_ip      (ifid_rs1),
        .ifid_rs2_ip      (ifid_rs2),
        .ex_valid_ip      (ex_valid),
        .ex_is_load_ip    (ex_is_load),
        .ex_mc_start_ip   (ex_mc_start),
        .flush_ip         (flush),
        .stall_cnt_clr_ip (clr),
        .fa_sel_op        (fa_sel),
        .fb_sel_op        (fb_sel),
        .stall_op         (stall),
        .bubble_op        (bubble),
        .ex_hold_op       (hold),
        .stall_cycles_op  (stall_cycles)
    );

    task automatic check_val(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0d expected=%0d", name, field, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.name, "stall_cycles", 32'(stall_cycles), 32'(e.cnt));
            if (!e.cnt_only) begin
                check_val(e.name, "fa_sel", 32'(fa_sel), 32'(e.fa));
                check_val(e.name, "fb_sel", 32'(fb_sel), 32'(e.fb));
                check_val(e.name, "stall",  32'(stall),  32'(e.stall));
                check_val(e.name, "bubble", 32'(bubble), 32'(e.bubble));
                check_val(e.name, "hold",   32'(hold),   32'(e.hold));
            end
        end
    end

    task automatic idle();
        idex_opcode  = 7'd0;
        idex_rs1     = 5'd0;
        idex_rs2     = 5'd0;
        stage_valid  = 2'b00;
        stage_wb_mux = '0;
        stage_dest   = '0;
        ifid_opcode  = 7'd0;
        ifid_rs1     = 5'd0;
        ifid_rs2     = 5'd0;
        ex_valid     = 1'b0;
        ex_is_load   = 1'b0;
        ex_mc_start  = 1'b0;
        flush        = 1'b0;
        clr          = 1'b0;
    endtask

    task automatic set_stages(input logic [1:0] vld, input logic [1:0] wb0, input logic [1:0] wb1,
                              input logic [RW-1:0] d0, input logic [RW-1:0] d1);
        stage_valid     = vld;
        stage_wb_mux[0] = wb0;
        stage_wb_mux[1] = wb1;
        stage_dest[0]   = d0;
        stage_dest[1]   = d1;
    endtask

    // Load in ID/EX writing x<dest> (carried on stage_dest[0]).
    task automatic set_load(input logic [RW-1:0] dest);
        ex_valid      = 1'b1;
        ex_is_load    = 1'b1;
        stage_dest[0] = dest;
    endtask

    task automatic expect_cycle(input string name, input logic [SW-1:0] fa, input logic [SW-1:0] fb,
                                input logic st, input logic bu, input logic ho,
                                input logic [CW-1:0] cnt, input logic cnt_only);
        exp_t e;
        e.name = name; e.cnt_only = cnt_only; e.fa = fa; e.fb = fb;
        e.stall = st; e.bubble = bu; e.hold = ho; e.cnt = cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_cycle("reset_state", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Forwarding
        idle(); idex_opcode = OPCODE_OP; idex_rs1 = 5'd1; idex_rs2 = 5'd2;
        set_stages(2'b11, WB_ALU, WB_MEM, 5'd1, 5'd2);
        expect_cycle("fwd_op", 2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        idle(); idex_opcode = OPCODE_OPIMM; idex_rs1 = 5'd5; idex_rs2 = 5'd5;
        set_stages(2'b11, WB_ALU, WB_ALU, 5'd5, 5'd5);
        expect_cycle("fwd_youngest", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        idle(); idex_opcode = OPCODE_OP; idex_rs1 = 5'd5; idex_rs2 = 5'd9;
        set_stages(2'b11, WB_ALU, WB_ALU, 5'd3, 5'd5);
        expect_cycle("fwd_older", 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        idle(); idex_opcode = OPCODE_OP;
        set_stages(2'b11, WB_ALU, WB_ALU, 5'd0, 5'd0);
        expect_cycle("fwd_dest0", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        idle(); idex_opcode = OPCODE_OP; idex_rs1 = 5'd4; idex_rs2 = 5'd4;
        set_stages(2'b11, NO_WRITEBACK, WB_ALU, 5'd4, 5'd4);
        expect_cycle("fwd_nowb", 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        idle(); idex_opcode = OPCODE_OP; idex_rs1 = 5'd4; idex_rs2 = 5'd4;
        set_stages(2'b00, WB_ALU, WB_ALU, 5'd4, 5'd4);
        expect_cycle("fwd_invalid", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        idle(); idex_opcode = OPCODE_STORE; idex_rs1 = 5'd6; idex_rs2 = 5'd7;
        set_stages(2'b11, WB_ALU, WB_ALU, 5'd7, 5'd6);
        expect_cycle("fwd_store", 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        idex_opcode = OPCODE_LUI;
        expect_cycle("fwd_lui", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Load-use
        idle(); set_load(5'd7); ifid_opcode = OPCODE_OP; ifid_rs1 = 5'd3; ifid_rs2 = 5'd7;
        expect_cycle("luse_rs2", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);

        idle(); ifid_opcode = OPCODE_OP; ifid_rs1 = 5'd3; ifid_rs2 = 5'd7;
        expect_cycle("luse_one_cycle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

        set_load(5'd7); flush = 1'b1;
        expect_cycle("luse_flush", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

        idle(); set_load(5'd7); ifid_opcode = OPCODE_OPIMM; ifid_rs1 = 5'd3; ifid_rs2 = 5'd7;
        expect_cycle("luse_rs2_unused", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

        idle(); set_load(5'd0); ifid_opcode = OPCODE_OP;
        expect_cycle("luse_dest0", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

        idle(); set_load(5'd7); ifid_opcode = OPCODE_LOAD; ifid_rs1 = 5'd7;
        expect_cycle("luse_rs1", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);

        // Multi-cycle hold: three held cycles, load-use ignored while busy
        idle(); ex_valid = 1'b1; ex_mc_start = 1'b1;
        expect_cycle("mc_enter", 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);

        idle(); set_load(5'd7); ifid_opcode = OPCODE_OP; ifid_rs2 = 5'd7; flush = 1'b1;
        expect_cycle("mc_busy1", 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
        expect_cycle("mc_busy2", 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);

        idle();
        expect_cycle("mc_done", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);

        // Statistics clear
        clr = 1'b1;
        expect_cycle("clr_cycle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
        clr = 1'b0;
        expect_cycle("clr_after", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        idle(); set_load(5'd7); ifid_opcode = OPCODE_OP; ifid_rs2 = 5'd7; clr = 1'b1;
        expect_cycle("clr_vs_stall", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        idle();
        expect_cycle("clr_priority", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Reset during the second MC_BUSY cycle
        ex_valid = 1'b1; ex_mc_start = 1'b1;
        expect_cycle("mc2_enter", 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
        idle();
        expect_cycle("mc2_busy1", 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        reset = 1'b1;
        expect_cycle("mc2_reset_cycle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
        reset = 1'b0;
        expect_cycle("mc2_after_reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Multi-cycle start qualifiers and priorities in RUN
        ex_mc_start = 1'b1;
        expect_cycle("mc_not_valid", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        ex_valid = 1'b1; flush = 1'b1;
        expect_cycle("mc_flush", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(); set_load(5'd7); ex_mc_start = 1'b1; ifid_opcode = OPCODE_OP; ifid_rs1 = 5'd7;
        expect_cycle("luse_over_mc", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        idle();
        expect_cycle("luse_over_mc_after", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
